// File: rtl/key_code_arbiter.sv
// Shares the synthesizer key_code input between the live keyboard and two demo players.
// Optional PREEMPT_EN: the keyboard preempts a demo owner through a forced release gap.
module key_code_arbiter #(
  parameter int GAP_CYCLES  = 16,
  parameter int HOLD_CYCLES = 256
) (
  input  logic       clock,
  input  logic       k_tr,
  input  logic [2:0] src_en,
  input  logic [7:0] code0,
  input  logic [7:0] code1,
  input  logic [7:0] code2,
  output logic [7:0] key_code,
  output logic [2:0] grant,
  output logic       busy
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_OWN    = 2'd1;
  localparam logic [1:0]  ST_GAP    = 2'd2;
  localparam logic [7:0]  NO_KEY    = 8'hf0;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_owner;
  logic [1:0]  r_pending;
  logic [1:0]  r_last_demo;
  logic [15:0] r_idle_cnt;
  logic [15:0] r_gap_cnt;
  logic [7:0]  r_key_code;
  logic [2:0]  r_grant;

  logic [2:0]  w_active;
  logic [1:0]  w_winner;
  logic [7:0]  w_winner_code;
  logic [7:0]  w_owner_code;
  logic [7:0]  w_pending_code;
  logic        w_owner_en;
  logic        w_owner_idle;

  function automatic logic [7:0] pick_code(input logic [1:0] sel, input logic [7:0] c0,
                                           input logic [7:0] c1, input logic [7:0] c2);
    case (sel)
      2'd0:    return c0;
      2'd1:    return c1;
      2'd2:    return c2;
      default: return NO_KEY;
    endcase
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] sel);
    return 3'b001 << sel;
  endfunction

  assign w_active = src_en & {code2 != NO_KEY, code1 != NO_KEY, code0 != NO_KEY};

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_winner = 2'd0;
    if (w_active[0])                     w_winner = 2'd0;
    else if (w_active[1] && w_active[2]) w_winner = (r_last_demo == 2'd1) ? 2'd2 : 2'd1;
    else if (w_active[1])                w_winner = 2'd1;
    else if (w_active[2])                w_winner = 2'd2;
  end

  assign w_winner_code  = pick_code(w_winner, code0, code1, code2);
  assign w_owner_code   = pick_code(r_owner, code0, code1, code2);
  assign w_pending_code = pick_code(r_pending, code0, code1, code2);
  assign w_owner_en     = |(src_en & one_hot(r_owner));
  assign w_owner_idle   = (w_owner_code == NO_KEY);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      r_state     <= ST_IDLE;
      r_owner     <= 2'd0;
      r_pending   <= 2'd0;
      r_last_demo <= 2'd2;
      r_idle_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_key_code  <= NO_KEY;
      r_grant     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_active) begin
            r_state    <= ST_OWN;
            r_owner    <= w_winner;
            r_grant    <= one_hot(w_winner);
            r_key_code <= w_winner_code;
            r_idle_cnt <= '0;
          end
        end
        ST_OWN: begin
          r_key_code <= w_owner_code;
          if (!w_owner_en || (w_owner_idle && r_idle_cnt == HOLD_LAST)) begin
            r_state    <= ST_IDLE;
            r_key_code <= NO_KEY;
            r_grant    <= '0;
            if (r_owner != 2'd0) r_last_demo <= r_owner;
          end
`ifdef PREEMPT_EN
          else if (r_owner != 2'd0 && w_active[0]) begin
            r_state     <= ST_GAP;
            r_pending   <= 2'd0;
            r_gap_cnt   <= '0;
            r_key_code  <= NO_KEY;
            r_grant     <= '0;
            r_last_demo <= r_owner;
          end
`endif
          else if (w_owner_idle) begin
            if (r_idle_cnt != 16'hffff) r_idle_cnt <= r_idle_cnt + 16'd1;
          end else begin
            r_idle_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            if (w_active[r_pending]) begin
              r_state    <= ST_OWN;
              r_owner    <= r_pending;
              r_grant    <= one_hot(r_pending);
              r_key_code <= w_pending_code;
              r_idle_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_gap_cnt != 16'hffff) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_code = r_key_code;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_key_code_arbiter.sv
// Directed self-checking bench for key_code_arbiter (default parameters 16 / 256).
module tb_key_code_arbiter;

  logic       clock = 1'b0;
  logic       k_tr  = 1'b0;
  logic [2:0] src_en = 3'b000;
  logic [7:0] code0 = 8'hf0;
  logic [7:0] code1 = 8'hf0;
  logic [7:0] code2 = 8'hf0;
  logic [7:0] key_code;
  logic [2:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  key_code_arbiter dut (
    .clock(clock), .k_tr(k_tr), .src_en(src_en),
    .code0(code0), .code1(code1), .code2(code2),
    .key_code(key_code), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] kc, input logic [2:0] gr,
                            input logic bz);
    n_checks++;
    if (key_code !== kc || grant !== gr || busy !== bz) begin
      n_fail++;
      $display("FAIL %s: key_code=%h grant=%b busy=%b, required key_code=%h grant=%b busy=%b",
               name, key_code, grant, busy, kc, gr, bz);
    end
  endtask

  task automatic pulse_reset();
    code0 = 8'hf0; code1 = 8'hf0; code2 = 8'hf0;
    k_tr = 1'b0;
    #2;
    k_tr = 1'b1;
  endtask

  task automatic test_reset();
    tick(1);
    expect_out("reset_state", 8'hf0, 3'b000, 1'b0);
    k_tr = 1'b1;
    src_en = 3'b111;
    tick(2);
    expect_out("idle_no_source", 8'hf0, 3'b000, 1'b0);
  endtask

  task automatic test_hold_timeout();
    code1 = 8'h2b;
    tick(1);
    expect_out("demo1_grant", 8'h2b, 3'b010, 1'b1);
    tick(4);
    expect_out("demo1_playing", 8'h2b, 3'b010, 1'b1);
    code1 = 8'hf0;
    tick(1);
    expect_out("demo1_note_off", 8'hf0, 3'b010, 1'b1);
    tick(254);
    expect_out("demo1_hold_255", 8'hf0, 3'b010, 1'b1);
    tick(1);
    expect_out("demo1_hold_drop", 8'hf0, 3'b000, 1'b0);
  endtask

  task automatic test_round_robin();
    pulse_reset();
    code1 = 8'h11;
    code2 = 8'h22;
    tick(1);
    expect_out("rr_first_src1", 8'h11, 3'b010, 1'b1);
    code1 = 8'hf0;
    tick(256);
    expect_out("rr_src1_released", 8'hf0, 3'b000, 1'b0);
    tick(1);
    expect_out("rr_src2_granted", 8'h22, 3'b100, 1'b1);
  endtask

  task automatic test_keyboard_vs_demo();
    pulse_reset();
    code2 = 8'h42;
    tick(1);
    expect_out("demo2_grant", 8'h42, 3'b100, 1'b1);
    code0 = 8'h34;
`ifdef PREEMPT_EN
    tick(1);
    expect_out("preempt_gap_start", 8'hf0, 3'b000, 1'b1);
    tick(15);
    expect_out("preempt_gap_end", 8'hf0, 3'b000, 1'b1);
    tick(1);
    expect_out("preempt_kbd_grant", 8'h34, 3'b001, 1'b1);
`else
    tick(10);
    expect_out("no_preempt_demo_held", 8'h42, 3'b100, 1'b1);
    code2 = 8'hf0;
    tick(256);
    expect_out("no_preempt_release", 8'hf0, 3'b000, 1'b0);
    tick(1);
    expect_out("no_preempt_kbd_grant", 8'h34, 3'b001, 1'b1);
`endif
  endtask

  task automatic test_en_drop();
    pulse_reset();
    code1 = 8'h55;
    tick(1);
    expect_out("en_drop_owner", 8'h55, 3'b010, 1'b1);
    src_en = 3'b101;
    tick(1);
    expect_out("en_drop_release", 8'hf0, 3'b000, 1'b0);
    tick(1);
    expect_out("en_drop_stays_idle", 8'hf0, 3'b000, 1'b0);
    src_en = 3'b111;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    code1 = 8'h66;
    tick(1);
    expect_out("mid_note_owner", 8'h66, 3'b010, 1'b1);
    #3 k_tr = 1'b0;
    #1 expect_out("mid_note_async_reset", 8'hf0, 3'b000, 1'b0);
    k_tr = 1'b1;
    tick(1);
    expect_out("after_reset_regrant", 8'h66, 3'b010, 1'b1);
`ifdef PREEMPT_EN
    pulse_reset();
    code2 = 8'h42;
    tick(1);
    code0 = 8'h34;
    tick(1);
    tick(7);
    expect_out("gap_count7", 8'hf0, 3'b000, 1'b1);
    #3 k_tr = 1'b0;
    #1 expect_out("mid_gap_async_reset", 8'hf0, 3'b000, 1'b0);
    k_tr = 1'b1;
    tick(1);
    expect_out("after_gap_reset_no_gap", 8'h34, 3'b001, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_hold_timeout();
    test_round_robin();
    test_keyboard_vs_demo();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
